// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Instruction sequencer between fetch and the shared datapath bus.
//   It latches one instruction word when start is accepted in IDLE, then
//   steps through the bus control strobes for an ALU operation (register or
//   immediate operand B), a register MOV, a NOP, or a rejected instruction.
//
//   Instruction layout (MSB first):
//     op[3:0] | rd[RSEL_W-1:0] | rs[RSEL_W-1:0] | m | imm[IW-6-2*RSEL_W:0]
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   start, instr    instruction valid / word, sampled only in IDLE
//   busy            high in every state except IDLE
//   pc_inc          PC increment strobe (FIN only)
//   alu_in1/2       latch bus into ALU operand A / B
//   alu_op          ALU function, valid while an ALU instruction is in flight
//   alu_out_latch   latch ALU result
//   alu_out_en      drive ALU result onto bus
//   g_out, g_in     one-hot register-to-bus / bus-to-register enables
//   imm_out_en      drive immediate onto bus
//   imm_val         zero-extended immediate of the latched instruction
//   done            one-cycle completion pulse
//   illegal         one-cycle pulse with done for a rejected instruction
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
   parameter int IW     = 16,
   parameter int NREG   = 4,
   parameter int RSEL_W = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [IW-1:0]   instr,
   output logic            busy,
   output logic            pc_inc,
   output logic            alu_in1,
   output logic            alu_in2,
   output logic [2:0]      alu_op,
   output logic            alu_out_latch,
   output logic            alu_out_en,
   output logic [NREG-1:0] g_out,
   output logic [NREG-1:0] g_in,
   output logic            imm_out_en,
   output logic [IW-1:0]   imm_val,
   output logic            done,
   output logic            illegal
);

   localparam int IMM_W = IW - 5 - 2 * RSEL_W;

   typedef enum logic [2:0] {
      IDLE, LD_A, LD_B, EXEC, WB, MOVE, FIN, ERR
   } state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] instr_q;

   // Fields of the incoming word, used only to choose the first state.
   logic [3:0]        in_op;
   logic [RSEL_W-1:0] in_rd, in_rs;
   logic              in_m;

   assign in_op = instr[IW-1 -: 4];
   assign in_rd = instr[IW-5 -: RSEL_W];
   assign in_rs = instr[IW-5-RSEL_W -: RSEL_W];
   assign in_m  = instr[IW-5-2*RSEL_W];

   // Fields of the latched word, which drive every output.
   logic [3:0]        q_op;
   logic [RSEL_W-1:0] q_rd, q_rs;
   logic              q_m;
   logic [IMM_W-1:0]  q_imm;

   assign q_op  = instr_q[IW-1 -: 4];
   assign q_rd  = instr_q[IW-5 -: RSEL_W];
   assign q_rs  = instr_q[IW-5-RSEL_W -: RSEL_W];
   assign q_m   = instr_q[IW-5-2*RSEL_W];
   assign q_imm = instr_q[IMM_W-1:0];

   // A select field can encode more registers than exist when NREG is not
   // a power of two.
   function automatic logic sel_bad(input logic [RSEL_W-1:0] sel);
      return 32'(sel) >= 32'(NREG);
   endfunction

   function automatic logic [NREG-1:0] onehot(input logic [RSEL_W-1:0] sel);
      return {{(NREG-1){1'b0}}, 1'b1} << sel;
   endfunction

   // rs only matters when it is actually read: ALU with a register operand,
   // or MOV. NOP still requires a valid rd.
   function automatic state_t decode(input logic [3:0]        op,
                                     input logic [RSEL_W-1:0] rd,
                                     input logic [RSEL_W-1:0] rs,
                                     input logic              m);
      if (op[3])
         return (sel_bad(rd) || (!m && sel_bad(rs))) ? ERR : LD_A;
      else if (op == 4'b0001)
         return (sel_bad(rd) || sel_bad(rs)) ? ERR : MOVE;
      else if (op == 4'b0000)
         return sel_bad(rd) ? ERR : FIN;
      else
         return ERR;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; the instruction latch is reset along with
   // the state so imm_val and alu_op read zero after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         instr_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start)
            instr_q <= instr;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt     = state;
      pc_inc        = 1'b0;
      alu_in1       = 1'b0;
      alu_in2       = 1'b0;
      alu_out_latch = 1'b0;
      alu_out_en    = 1'b0;
      g_out         = '0;
      g_in          = '0;
      imm_out_en    = 1'b0;
      done          = 1'b0;
      illegal       = 1'b0;

      unique case (state)
         IDLE: if (start) state_nxt = decode(in_op, in_rd, in_rs, in_m);
         LD_A: begin
            g_out     = onehot(q_rd);
            alu_in1   = 1'b1;
            state_nxt = LD_B;
         end
         LD_B: begin
            if (q_m) imm_out_en = 1'b1;
            else     g_out      = onehot(q_rs);
            alu_in2   = 1'b1;
            state_nxt = EXEC;
         end
         EXEC: begin
            alu_out_latch = 1'b1;
            state_nxt     = WB;
         end
         WB: begin
            alu_out_en = 1'b1;
            g_in       = onehot(q_rd);
            state_nxt  = FIN;
         end
         MOVE: begin
            g_out     = onehot(q_rs);
            g_in      = onehot(q_rd);
            state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = IDLE;
         end
         ERR: begin
            done      = 1'b1;
            illegal   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign alu_op  = (busy && q_op[3]) ? q_op[2:0] : 3'b000;
   assign imm_val = {{(IW-IMM_W){1'b0}}, q_imm};

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//   Table-driven bench for alu_seq_ctrl. Each vector holds an instruction
//   and the hand-written per-cycle strobe pattern expected from the cycle
//   after acceptance up to the done cycle. A second instance with NREG=3
//   covers out-of-range register selects. A hand-written sequence covers
//   reset in the middle of an ALU operation and a start pulse while busy.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

   typedef struct packed {
      logic       busy, pc_inc, alu_in1, alu_in2, alu_out_latch, alu_out_en;
      logic [3:0] g_out, g_in;
      logic       imm_out_en, done, illegal;
   } obs_t;

   typedef struct packed {
      logic [15:0]     instr;
      logic [2:0]      n;       // cycles from accept to done inclusive
      logic            is_alu;
      logic [2:0]      alu_op;
      logic [15:0]     imm;
      obs_t [4:0]      exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic        start;
   logic [15:0] instr;
   logic        busy, pc_inc, alu_in1, alu_in2, alu_out_latch, alu_out_en;
   logic [2:0]  alu_op;
   logic [3:0]  g_out, g_in;
   logic        imm_out_en, done, illegal;
   logic [15:0] imm_val;

   alu_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .instr(instr),
      .busy(busy), .pc_inc(pc_inc), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_op(alu_op), .alu_out_latch(alu_out_latch), .alu_out_en(alu_out_en),
      .g_out(g_out), .g_in(g_in), .imm_out_en(imm_out_en), .imm_val(imm_val),
      .done(done), .illegal(illegal)
   );

   // NREG=3 instance
   logic        start3;
   logic [15:0] instr3;
   logic        busy3, pc_inc3, alu_in13, alu_in23, alu_out_latch3, alu_out_en3;
   logic [2:0]  alu_op3;
   logic [2:0]  g_out3, g_in3;
   logic        imm_out_en3, done3, illegal3;
   logic [15:0] imm_val3;

   alu_seq_ctrl #(.IW(16), .NREG(3), .RSEL_W(2)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .instr(instr3),
      .busy(busy3), .pc_inc(pc_inc3), .alu_in1(alu_in13), .alu_in2(alu_in23),
      .alu_op(alu_op3), .alu_out_latch(alu_out_latch3), .alu_out_en(alu_out_en3),
      .g_out(g_out3), .g_in(g_in3), .imm_out_en(imm_out_en3), .imm_val(imm_val3),
      .done(done3), .illegal(illegal3)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic obs_t mk(input logic b, pc, i1, i2, lat, oen,
                               input logic [3:0] go, gi,
                               input logic imm, dn, il);
      obs_t o;
      o.busy = b; o.pc_inc = pc; o.alu_in1 = i1; o.alu_in2 = i2;
      o.alu_out_latch = lat; o.alu_out_en = oen; o.g_out = go; o.g_in = gi;
      o.imm_out_en = imm; o.done = dn; o.illegal = il;
      return o;
   endfunction

   // Hand-written expected patterns for each state
   function automatic obs_t ld_a(input logic [3:0] g);     return mk(1,0,1,0,0,0,g,4'b0,0,0,0); endfunction
   function automatic obs_t ld_b_reg(input logic [3:0] g); return mk(1,0,0,1,0,0,g,4'b0,0,0,0); endfunction
   function automatic obs_t ld_b_imm();                    return mk(1,0,0,1,0,0,4'b0,4'b0,1,0,0); endfunction
   function automatic obs_t exec_o();                      return mk(1,0,0,0,1,0,4'b0,4'b0,0,0,0); endfunction
   function automatic obs_t wb(input logic [3:0] g);       return mk(1,0,0,0,0,1,4'b0,g,0,0,0); endfunction
   function automatic obs_t move(input logic [3:0] go, gi);return mk(1,0,0,0,0,0,go,gi,0,0,0); endfunction
   function automatic obs_t fin_o();                       return mk(1,1,0,0,0,0,4'b0,4'b0,0,1,0); endfunction
   function automatic obs_t err_o();                       return mk(1,0,0,0,0,0,4'b0,4'b0,0,1,1); endfunction

   function automatic obs_t cur();
      return mk(busy, pc_inc, alu_in1, alu_in2, alu_out_latch, alu_out_en,
                g_out, g_in, imm_out_en, done, illegal);
   endfunction

   function automatic obs_t cur3();
      return mk(busy3, pc_inc3, alu_in13, alu_in23, alu_out_latch3, alu_out_en3,
                {1'b0, g_out3}, {1'b0, g_in3}, imm_out_en3, done3, illegal3);
   endfunction

   task automatic setv(output vec_t v, input logic [15:0] i, input logic [2:0] n,
                       input logic a, input logic [2:0] op, input logic [15:0] imm,
                       input obs_t e0, e1, e2, e3, e4);
      v.instr = i; v.n = n; v.is_alu = a; v.alu_op = op; v.imm = imm;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
   endtask

   // Called at a negedge while the selected instance is idle. Checks the
   // idle outputs, raises start, then checks every cycle up to done.
   // With poke set, a different start/instr is offered while busy.
   task automatic run_vec(input vec_t v, input bit on3, input bit poke, input string tag);
      obs_t o;
      check({tag, " idle"}, 32'(on3 ? cur3() : cur()), 32'(obs_t'('0)));
      if (on3) begin start3 = 1'b1; instr3 = v.instr; end
      else     begin start  = 1'b1; instr  = v.instr; end
      for (int j = 0; j < int'(v.n); j++) begin
         @(negedge clk);
         if (on3) begin start3 = 1'b0; instr3 = 16'($urandom); end
         else     begin start  = 1'b0; instr  = 16'($urandom); end
         if (poke && j == 1) begin start = 1'b1; instr = 16'h1E00; end
         o = on3 ? cur3() : cur();
         check($sformatf("%s c%0d strobes", tag, j + 1), 32'(o), 32'(v.exp[j]));
         check($sformatf("%s c%0d imm_val", tag, j + 1),
               32'(on3 ? imm_val3 : imm_val), 32'(v.imm));
         if (v.is_alu)
            check($sformatf("%s c%0d alu_op", tag, j + 1),
                  32'(on3 ? alu_op3 : alu_op), 32'(v.alu_op));
      end
   endtask

   vec_t vecs  [9];
   vec_t vecs3 [3];

   initial begin
      obs_t z;
      z = '0;
      //        instr     n  alu op      imm
      setv(vecs[0], 16'h9002, 3'd5, 1, 3'b001, 16'h0002, ld_a(4'b0001), ld_b_reg(4'b0001), exec_o(), wb(4'b0001), fin_o());
      setv(vecs[1], 16'hA6A5, 3'd5, 1, 3'b010, 16'h0025, ld_a(4'b0010), ld_b_imm(),        exec_o(), wb(4'b0010), fin_o());
      setv(vecs[2], 16'h1E00, 3'd2, 0, 3'b000, 16'h0000, move(4'b0100, 4'b1000), fin_o(), z, z, z);
      setv(vecs[3], 16'h0000, 3'd1, 0, 3'b000, 16'h0000, fin_o(), z, z, z, z);
      setv(vecs[4], 16'h3000, 3'd1, 0, 3'b000, 16'h0000, err_o(), z, z, z, z);
      setv(vecs[5], 16'hF500, 3'd5, 1, 3'b111, 16'h0000, ld_a(4'b0010), ld_b_reg(4'b0010), exec_o(), wb(4'b0010), fin_o());
      setv(vecs[6], 16'h1500, 3'd2, 0, 3'b000, 16'h0000, move(4'b0010, 4'b0010), fin_o(), z, z, z);
      setv(vecs[7], 16'h8B00, 3'd5, 1, 3'b000, 16'h0000, ld_a(4'b0100), ld_b_reg(4'b1000), exec_o(), wb(4'b0100), fin_o());
      setv(vecs[8], 16'h7FFF, 3'd1, 0, 3'b000, 16'h007F, err_o(), z, z, z, z);
      // NREG=3: rd=3 illegal, MOV rs=3 illegal, ALU m=1 with rs=3 legal
      setv(vecs3[0], 16'h9C00, 3'd1, 0, 3'b000, 16'h0000, err_o(), z, z, z, z);
      setv(vecs3[1], 16'h1300, 3'd1, 0, 3'b000, 16'h0000, err_o(), z, z, z, z);
      setv(vecs3[2], 16'h9380, 3'd5, 1, 3'b001, 16'h0000, ld_a(4'b0001), ld_b_imm(), exec_o(), wb(4'b0001), fin_o());

      rst = 1'b0; start = 1'b0; instr = '0; start3 = 1'b0; instr3 = '0;
      repeat (2) @(negedge clk);
      check("reset strobes", 32'(cur()), 32'(z));
      check("reset alu_op/imm", {13'd0, alu_op, imm_val}, 32'd0);
      rst = 1'b1;

      // Back-to-back: each vector starts in the idle cycle after done.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         run_vec(vecs[i], 1'b0, 1'b0, $sformatf("v%0d", i));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         run_vec(vecs3[i], 1'b1, 1'b0, $sformatf("n3v%0d", i));
      end

      // Reset during EXEC of an ALU op
      @(negedge clk);
      start = 1'b1; instr = 16'h9002;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         start = 1'b0;
         check($sformatf("rs c%0d strobes", j + 1), 32'(cur()), 32'(vecs[0].exp[j]));
      end
      #2 rst = 1'b0;
      #1;
      check("rs async strobes", 32'(cur()), 32'(z));
      check("rs async alu_op/imm", {13'd0, alu_op, imm_val}, 32'd0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check($sformatf("rs hold c%0d", j), 32'(cur()), 32'(z));
      end
      // Release with start already high: accepted at the first rising edge.
      rst = 1'b1;
      run_vec(vecs[7], 1'b0, 1'b1, "post-rst");
      @(negedge clk);
      check("final idle", 32'(cur()), 32'(z));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Parametrised successor to the microcontroller's ALU control FSM.
- Latches one instruction word on a start/busy handshake and sequences the shared-bus control strobes: register out/in enables, ALU operand latches, ALU result latch/enable and PC increment.
- Adds over the previous generation: N general registers, immediate-operand mode, register MOV, NOP and illegal-opcode detection.
- Sits between instruction fetch and the datapath bus.

Parameters:
- IW, 16, instruction width in bits (minimum 16).
- NREG, 4, number of general registers G0..G(NREG-1) (2..2**RSEL_W).
- RSEL_W, 2, width of the rd and rs register-select fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  instruction valid; sampled only in IDLE.
- instr  in  IW  instruction word; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- pc_inc  out  1  PC increment strobe.
- alu_in1  out  1  latch bus into ALU operand A.
- alu_in2  out  1  latch bus into ALU operand B.
- alu_op  out  3  ALU function; held from accept until IDLE.
- alu_out_latch  out  1  latch ALU result.
- alu_out_en  out  1  drive ALU result onto bus.
- g_out  out  NREG  one-hot register-to-bus enable.
- g_in  out  NREG  one-hot bus-to-register load.
- imm_out_en  out  1  drive immediate onto bus.
- imm_val  out  IW  zero-extended immediate.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse, coincident with done, for a rejected instruction.

Behaviour:
- Instruction fields:
  - op = instr[IW-1:IW-4].
  - rd = next RSEL_W bits below op.
  - rs = next RSEL_W bits below rd.
  - m = instr[IW-5-2*RSEL_W].
  - imm = instr[IW-6-2*RSEL_W:0], zero-extended into imm_val.
- Opcode decode:
  - op[3]=1: ALU operation, alu_op = op[2:0].
  - op=4'b0001: MOV rd <- rs.
  - op=4'b0000: NOP.
  - op 0010..0111: illegal.
  - rd>=NREG or rs>=NREG: illegal. rs is ignored when the instruction is ALU with m=1, or NOP.
- States: IDLE, LD_A, LD_B, EXEC, WB, MOVE, FIN, ERR.
- Outputs are Moore, decoded from the state register and the latched instruction. Every strobe not listed for a state is 0.
  - IDLE: all strobes 0.
  - LD_A: g_out[rd], alu_in1.
  - LD_B:
    - m=0: g_out[rs], alu_in2.
    - m=1: imm_out_en, alu_in2.
  - EXEC: alu_out_latch.
  - WB: alu_out_en, g_in[rd].
  - MOVE: g_out[rs], g_in[rd].
  - FIN: done, pc_inc.
  - ERR: done, illegal. pc_inc stays 0.
- Transitions:
  - IDLE -> (start=1) latch instr, then branch on decode: ALU -> LD_A; MOV -> MOVE; NOP -> FIN; illegal -> ERR.
  - LD_A -> LD_B -> EXEC -> WB -> FIN.
  - MOVE -> FIN.
  - FIN -> IDLE; ERR -> IDLE.
- Latency, with start accepted at edge k (k = edge index):
  - ALU: done high in cycle k+5.
  - MOV: done high in cycle k+2.
  - NOP and illegal: done high in cycle k+1.
  - start may be reasserted in the cycle after done, giving back-to-back instructions.
- start and instr changes while busy are ignored. The latched instruction stays stable until IDLE.
- rd==rs is legal. For MOV, g_out[rd] and g_in[rd] are both high for one cycle.
- g_out and g_in are never more than one-hot.
- At most one bus driver (any g_out, alu_out_en, imm_out_en) is active per cycle.
- Reset:
  - rst=0 forces IDLE asynchronously.
  - All outputs go to 0, imm_val and alu_op go to 0, and the latched instruction clears.
  - Reset mid-operation aborts with no done pulse.
  - The first start is accepted on the first rising edge after rst deasserts.

Test Plan:
- Default parameters, instr=16'h9002, start for one cycle:
  - LD_A has g_out=4'b0001, alu_in1.
  - LD_B has g_out=4'b0001, alu_in2.
  - EXEC has alu_out_latch.
  - WB has alu_out_en, g_in=4'b0001.
  - FIN has done and pc_inc.
  - alu_op=3'b001 throughout.
- instr=16'hA6A5 (ALU, rd=1, rs=2, m=1):
  - LD_B has imm_out_en=1, g_out=0, imm_val=16'h0025.
  - WB has g_in=4'b0010.
- instr=16'h1E00 (MOV rd=3, rs=2): one cycle with g_out=4'b0100 and g_in=4'b1000, then done and pc_inc; done high at k+2.
- instr=16'h0000, then 16'h3000 back-to-back:
  - NOP: done and pc_inc at k+1.
  - Illegal: done and illegal at k+1, pc_inc=0.
- NREG=3, instr=16'h9C00 (rd=3): ERR path with illegal=1 and no g_in activity.
- rst=0 asserted during EXEC of an ALU op:
  - All outputs are 0 immediately, busy=0, no done.
  - A new start after release runs normally.
  - A start pulse while busy is ignored and the latched instr is unchanged.
